fetch_pc_stage: RTL and testbench
=================================

FETCH_PC_STAGE -- requirements
Module: fetch_pc_stage

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set PC and instruction-address width.
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value loaded at reset.
REQ-003 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 next_pc_i  input  ADDR_W  SHALL carry the next PC selected by the upstream 2:1 PC mux.
REQ-006 redirect_i  input  1  SHALL flag a taken branch/jump; next_pc_i is then the target.
REQ-007 stall_i  input  1  SHALL carry the decode hazard stall.
REQ-008 imem_req_o  output  1  SHALL be the instruction-memory request valid.
REQ-009 imem_addr_o  output  ADDR_W  SHALL be the request address.
REQ-010 imem_ack_i  input  1  SHALL be the request acknowledge; imem_data_i is valid in the same cycle.
REQ-011 imem_data_i  input  32  SHALL be the fetched instruction.
REQ-012 pc_o, pc4_o  output  ADDR_W  SHALL be the current PC and PC+4 (mux data0 source).
REQ-013 ifid_valid_o, ifid_pc4_o, ifid_instr_o  output  1/ADDR_W/32  SHALL be the IF/ID register.

Function
REQ-014 FSM states SHALL be BOOT, FETCH, HOLD, DROP.
REQ-015 BOOT SHALL last exactly one cycle after reset release, with imem_req_o=0, then go to FETCH.
REQ-016 FETCH SHALL drive imem_req_o=1, imem_addr_o=pc_o, both held stable until imem_ack_i.
REQ-017 FETCH, ack, !stall_i, !redirect_i: IF/ID SHALL load {1, pc_o+4, imem_data_i}, pc SHALL load next_pc_i, state remains FETCH (one instruction per cycle at zero wait).
REQ-018 FETCH, ack, stall_i: instruction SHALL be held in a one-entry buffer, IF/ID and pc unchanged, go to HOLD.
REQ-019 HOLD SHALL drive imem_req_o=0; on !stall_i, IF/ID SHALL load the buffered entry, pc SHALL load next_pc_i, go to FETCH.
REQ-020 FETCH, no ack, stall_i: request SHALL stay asserted; on ack the HOLD rule applies.
REQ-021 redirect_i SHALL take priority over stall_i: ifid_valid_o SHALL be 0 next cycle, pc SHALL load next_pc_i, buffer SHALL be discarded.
REQ-022 redirect_i while a request is unacknowledged: the request SHALL complete, data discarded (state DROP), then FETCH from the new pc.
REQ-023 Simultaneous ack and redirect_i in FETCH SHALL discard the data and go straight to FETCH at next_pc_i.
REQ-024 next_pc_i[1:0] SHALL be ignored; pc[1:0] SHALL always be 0.
REQ-025 pc4_o SHALL be combinational pc_o+4, wrapping modulo 2^ADDR_W.
REQ-026 While stall_i=1, IF/ID outputs SHALL hold their values.

Reset
REQ-027 On rst_i=0, asynchronously: pc_o=RESET_PC, state=BOOT, imem_req_o=0, ifid_valid_o=0, ifid_pc4_o=0, ifid_instr_o=0, buffer empty.
REQ-028 Reset mid-request SHALL abandon the request; no ack arriving after reset release is consumed before FETCH.

Configuration
REQ-029 With FETCH_STALL_CNT_EN defined, output stall_cnt_o (32) SHALL count cycles in HOLD or FETCH-without-ack, saturating at all-ones, reset to 0.
REQ-030 Without FETCH_STALL_CNT_EN, stall_cnt_o and its counter SHALL not exist; all other behaviour identical.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enum, INSTR_W=32 and NOP=32'h0.
REQ-032 The IF/ID register with load/hold/clear controls SHALL be sub-module if_id_reg.

Verification
REQ-033 Reset release, ack always 1: addresses 0,4,8,12 on consecutive cycles from cycle 2; ifid_pc4_o 4,8,12.
REQ-034 stall_i=1 for 3 cycles after ack at 0x8: IF/ID holds 0x8 entry, req low, then 0xC fetched with no lost instruction.
REQ-035 Ack delayed 4 cycles: imem_addr_o stable at 0x10, stall_cnt_o +4 when FETCH_STALL_CNT_EN.
REQ-036 redirect_i to 0x40 with outstanding request: data discarded, ifid_valid_o=0, next address 0x40.
REQ-037 RESET_PC=0xFFFFFFFC: pc4_o=0, next fetch at 0x0.
REQ-038 rst_i low mid-HOLD: all outputs at reset values immediately, restart at RESET_PC after BOOT.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC stage.
// The optional stall counter is enabled with the FETCH_STALL_CNT_EN macro.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear has priority over load; otherwise it holds.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i_load,
    input  logic               i_clr,
    input  logic [ADDR_W-1:0]  i_pc4,
    input  logic [INSTR_W-1:0] i_instr,
    output logic               o_valid,
    output logic [ADDR_W-1:0]  o_pc4,
    output logic [INSTR_W-1:0] o_instr
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            o_valid <= 1'b0;
            o_pc4   <= '0;
            o_instr <= NOP;
        end else if (i_clr) begin
            o_valid <= 1'b0;
            o_pc4   <= '0;
            o_instr <= NOP;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_pc4   <= i_pc4;
            o_instr <= i_instr;
        end
    end

endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch stage: PC register, instruction-memory request FSM, one-entry stall buffer, IF/ID.
// Define FETCH_STALL_CNT_EN to add the stall_cnt_o cycle counter.
module fetch_pc_stage
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [ADDR_W-1:0]  next_pc_i,
    input  logic               redirect_i,
    input  logic               stall_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [ADDR_W-1:0]  pc4_o,
    output logic               ifid_valid_o,
    output logic [ADDR_W-1:0]  ifid_pc4_o,
    output logic [INSTR_W-1:0] ifid_instr_o
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt_o
`endif
);

    localparam logic [ADDR_W-1:0] PC_MASK          = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = RESET_PC & PC_MASK;

    fetch_state_e        r_state;
    fetch_state_e        w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_drop_addr;
    logic                r_buf_valid;
    logic [ADDR_W-1:0]   r_buf_pc4;
    logic [INSTR_W-1:0]  r_buf_instr;

    logic [ADDR_W-1:0]   w_pc4;
    logic [ADDR_W-1:0]   w_next_pc;
    logic                w_pc_load;
    logic                w_drop_load;
    logic                w_buf_load;
    logic                w_buf_clr;
    logic                w_ifid_load;
    logic                w_ifid_clr;
    logic                w_ifid_from_buf;
    logic [ADDR_W-1:0]   w_ifid_pc4_in;
    logic [INSTR_W-1:0]  w_ifid_instr_in;

    assign w_pc4     = r_pc + ADDR_W'(4);
    assign w_next_pc = next_pc_i & PC_MASK;
    assign pc_o      = r_pc;
    assign pc4_o     = w_pc4;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A request, once issued, always runs to its ack; DROP swallows a redirected one.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT:  w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (redirect_i && !imem_ack_i) begin
                    w_state_nxt = ST_DROP;
                end else if (imem_ack_i && !redirect_i && stall_i) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD:  begin
                if (redirect_i || !stall_i) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DROP:  begin
                if (imem_ack_i) begin
                    w_state_nxt = ST_FETCH;
                end
            end
        endcase
    end

    // An unstalled cycle that delivers nothing to decode leaves a bubble in IF/ID.
    always_comb begin
        imem_req_o      = 1'b0;
        imem_addr_o     = r_pc;
        w_pc_load       = 1'b0;
        w_drop_load     = 1'b0;
        w_buf_load      = 1'b0;
        w_buf_clr       = 1'b0;
        w_ifid_load     = 1'b0;
        w_ifid_clr      = 1'b0;
        w_ifid_from_buf = 1'b0;
        case (r_state)
            ST_BOOT: ;
            ST_FETCH: begin
                imem_req_o = 1'b1;
                if (redirect_i) begin
                    w_pc_load   = 1'b1;
                    w_ifid_clr  = 1'b1;
                    w_buf_clr   = 1'b1;
                    w_drop_load = !imem_ack_i;
                end else if (imem_ack_i && !stall_i) begin
                    w_ifid_load = 1'b1;
                    w_pc_load   = 1'b1;
                end else if (imem_ack_i) begin
                    w_buf_load = 1'b1;
                end else if (!stall_i) begin
                    w_ifid_clr = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_i) begin
                    w_pc_load  = 1'b1;
                    w_ifid_clr = 1'b1;
                    w_buf_clr  = 1'b1;
                end else if (!stall_i) begin
                    w_ifid_load     = r_buf_valid;
                    w_ifid_from_buf = 1'b1;
                    w_pc_load       = 1'b1;
                    w_buf_clr       = 1'b1;
                end
            end
            ST_DROP: begin
                imem_req_o  = 1'b1;
                imem_addr_o = r_drop_addr;
                w_pc_load   = redirect_i;
                w_ifid_clr  = redirect_i || !stall_i;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc        <= RESET_PC_ALIGNED;
            r_drop_addr <= '0;
            r_buf_valid <= 1'b0;
            r_buf_pc4   <= '0;
            r_buf_instr <= NOP;
        end else begin
            if (w_pc_load) begin
                r_pc <= w_next_pc;
            end
            if (w_drop_load) begin
                r_drop_addr <= r_pc;
            end
            if (w_buf_load) begin
                r_buf_valid <= 1'b1;
                r_buf_pc4   <= w_pc4;
                r_buf_instr <= imem_data_i;
            end else if (w_buf_clr) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    assign w_ifid_pc4_in   = w_ifid_from_buf ? r_buf_pc4   : w_pc4;
    assign w_ifid_instr_in = w_ifid_from_buf ? r_buf_instr : imem_data_i;

    if_id_reg #(
        .ADDR_W (ADDR_W)
    ) u_if_id_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_load  (w_ifid_load),
        .i_clr   (w_ifid_clr),
        .i_pc4   (w_ifid_pc4_in),
        .i_instr (w_ifid_instr_in),
        .o_valid (ifid_valid_o),
        .o_pc4   (ifid_pc4_o),
        .o_instr (ifid_instr_o)
    );

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Cycles spent waiting on memory or on decode, saturating.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if (((r_state == ST_HOLD) || ((r_state == ST_FETCH) && !imem_ack_i))
                     && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Self-checking bench for fetch_pc_stage: directed scenarios plus randomized traffic
// checked against a transaction-level fetch model.
module tb_fetch_pc_stage;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] next_pc_i = '0;
    logic        redirect_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;

    wire         imem_req_o;
    wire  [31:0] imem_addr_o;
    wire  [31:0] pc_o;
    wire  [31:0] pc4_o;
    wire         ifid_valid_o;
    wire  [31:0] ifid_pc4_o;
    wire  [31:0] ifid_instr_o;

    logic [31:0] w_next_pc = '0;
    wire         w_req;
    wire  [31:0] w_addr;
    wire  [31:0] w_pc;
    wire  [31:0] w_pc4;
    wire         w_ifid_valid;
    wire  [31:0] w_ifid_pc4;
    wire  [31:0] w_ifid_instr;

`ifdef FETCH_STALL_CNT_EN
    wire  [31:0] stall_cnt_o;
    wire  [31:0] w_stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: in-order fetch stream with one held entry.
    bit          m_boot;
    bit          m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_drop_addr;
    logic        m_v;
    logic [31:0] m_ipc4;
    logic [31:0] m_ins;
    logic [63:0] m_held[$];
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    fetch_pc_stage #(
        .ADDR_W   (32),
        .RESET_PC (32'h0)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .next_pc_i    (next_pc_i),
        .redirect_i   (redirect_i),
        .stall_i      (stall_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .pc_o         (pc_o),
        .pc4_o        (pc4_o),
        .ifid_valid_o (ifid_valid_o),
        .ifid_pc4_o   (ifid_pc4_o),
        .ifid_instr_o (ifid_instr_o)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    fetch_pc_stage #(
        .ADDR_W   (32),
        .RESET_PC (WRAP_PC)
    ) u_dut_wrap (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .next_pc_i    (w_next_pc),
        .redirect_i   (1'b0),
        .stall_i      (1'b0),
        .imem_req_o   (w_req),
        .imem_addr_o  (w_addr),
        .imem_ack_i   (1'b1),
        .imem_data_i  (32'h1234_5678),
        .pc_o         (w_pc),
        .pc4_o        (w_pc4),
        .ifid_valid_o (w_ifid_valid),
        .ifid_pc4_o   (w_ifid_pc4),
        .ifid_instr_o (w_ifid_instr)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt_o  (w_stall_cnt)
`endif
    );

    task automatic model_reset();
        m_boot = 1'b1; m_drop = 1'b0; m_pc = '0; m_drop_addr = '0;
        m_v = 1'b0; m_ipc4 = '0; m_ins = '0; m_cnt = '0;
        m_held.delete();
    endtask

    task automatic model_clear();
        m_v = 1'b0; m_ipc4 = '0; m_ins = '0;
    endtask

    task automatic model_step();
        logic [31:0] np;
        logic [63:0] e;
        np = next_pc_i & 32'hFFFF_FFFC;
        if (((!m_boot && !m_drop && m_held.size() == 0 && !imem_ack_i) || m_held.size() != 0)
            && m_cnt != 32'hFFFF_FFFF)
            m_cnt = m_cnt + 32'd1;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_held.size() != 0) begin
            if (redirect_i) begin
                m_held.delete(); m_pc = np; model_clear();
            end else if (!stall_i) begin
                e = m_held.pop_front();
                m_v = 1'b1; m_ipc4 = e[63:32]; m_ins = e[31:0]; m_pc = np;
            end
        end else if (m_drop) begin
            if (redirect_i) m_pc = np;
            if (redirect_i || !stall_i) model_clear();
            if (imem_ack_i) m_drop = 1'b0;
        end else begin
            if (redirect_i) begin
                if (!imem_ack_i) begin
                    m_drop = 1'b1; m_drop_addr = m_pc;
                end
                m_pc = np; model_clear();
            end else if (imem_ack_i) begin
                e = {m_pc + 32'd4, imem_data_i};
                if (stall_i) m_held.push_back(e);
                else begin
                    m_v = 1'b1; m_ipc4 = e[63:32]; m_ins = e[31:0]; m_pc = np;
                end
            end else if (!stall_i) begin
                model_clear();
            end
        end
    endtask

    // Inputs change just after the falling edge; upstream mux picks target or pc+4.
    task automatic drive(input logic rd, input logic st, input logic ak,
                         input logic [31:0] dat, input logic [31:0] tgt);
        redirect_i  = rd;
        stall_i     = st;
        imem_ack_i  = ak;
        imem_data_i = dat;
        next_pc_i   = rd ? tgt : (m_pc + 32'd4);
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_i = 1'b0; stall_i = 1'b0; imem_ack_i = 1'b0; imem_data_i = '0; next_pc_i = '0;
        @(negedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h0); end
        n_tests++; if (pc4_o !== 32'h4) begin n_fail++; $display("FAIL reset_pc4: got %h expected %h", pc4_o, 32'h4); end
        n_tests++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
        n_tests++; if (ifid_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ifid_valid_o); end
        n_tests++; if (ifid_pc4_o !== 32'h0) begin n_fail++; $display("FAIL reset_ifid_pc4: got %h expected 0", ifid_pc4_o); end
        n_tests++; if (ifid_instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_ifid_instr: got %h expected 0", ifid_instr_o); end
        n_tests++; if (w_pc !== WRAP_PC) begin n_fail++; $display("FAIL reset_wrap_pc: got %h expected %h", w_pc, WRAP_PC); end
`ifdef FETCH_STALL_CNT_EN
        n_tests++; if (stall_cnt_o !== 32'h0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt_o); end
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_0000, 32'h0);
        n_tests++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL seq_boot_req: got %b expected 0", imem_req_o); end
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'hA000_0000 + 32'(i), 32'h0);
            n_tests++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL seq_req[%0d]: got %b expected 1", i, imem_req_o); end
            n_tests++; if (imem_addr_o !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, imem_addr_o, 32'(4 * i)); end
            if (i > 0) begin
                n_tests++; if (ifid_pc4_o !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_ifid_pc4[%0d]: got %h expected %h", i, ifid_pc4_o, 32'(4 * i)); end
                n_tests++; if (ifid_instr_o !== 32'hA000_0000 + 32'(i - 1)) begin n_fail++; $display("FAIL seq_ifid_instr[%0d]: got %h expected %h", i, ifid_instr_o, 32'hA000_0000 + 32'(i - 1)); end
                n_tests++; if (ifid_valid_o !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, ifid_valid_o); end
            end
            advance();
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'hB000_0000 + 32'(i), 32'h0);
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b1, (k == 0) ? 32'hB000_0003 : 32'hEEEE_EEEE, 32'h0);
            n_tests++; if (imem_req_o !== (k == 0)) begin n_fail++; $display("FAIL stall_req[%0d]: got %b expected %b", k, imem_req_o, k == 0); end
            n_tests++; if (ifid_pc4_o !== 32'hC) begin n_fail++; $display("FAIL stall_ifid_pc4[%0d]: got %h expected c", k, ifid_pc4_o); end
            n_tests++; if (ifid_instr_o !== 32'hB000_0002) begin n_fail++; $display("FAIL stall_ifid_instr[%0d]: got %h expected b0000002", k, ifid_instr_o); end
            advance();
        end
        drive(1'b0, 1'b0, 1'b1, 32'hEEEE_EEEE, 32'h0);
        n_tests++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_release_req: got %b expected 0", imem_req_o); end
        advance();
        drive(1'b0, 1'b0, 1'b1, 32'hB000_0004, 32'h0);
        n_tests++; if (ifid_pc4_o !== 32'h10) begin n_fail++; $display("FAIL stall_buf_pc4: got %h expected 10", ifid_pc4_o); end
        n_tests++; if (ifid_instr_o !== 32'hB000_0003) begin n_fail++; $display("FAIL stall_buf_instr: got %h expected b0000003", ifid_instr_o); end
        n_tests++; if (imem_addr_o !== 32'h10 || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL stall_next_addr: got %h/%b expected 10/1", imem_addr_o, imem_req_o); end
        advance();
        n_tests++; if (ifid_pc4_o !== 32'h14) begin n_fail++; $display("FAIL stall_after_pc4: got %h expected 14", ifid_pc4_o); end
    endtask

    task automatic test_ack_delay();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'hC000_0000 + 32'(i), 32'h0);
            advance();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'hEEEE_EEEE, 32'h0);
            n_tests++; if (imem_addr_o !== 32'h10 || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL delay_addr[%0d]: got %h/%b expected 10/1", k, imem_addr_o, imem_req_o); end
            advance();
        end
        drive(1'b0, 1'b0, 1'b1, 32'hC0DE_0010, 32'h0);
        n_tests++; if (imem_addr_o !== 32'h10) begin n_fail++; $display("FAIL delay_ack_addr: got %h expected 10", imem_addr_o); end
`ifdef FETCH_STALL_CNT_EN
        n_tests++; if (stall_cnt_o !== 32'd4) begin n_fail++; $display("FAIL delay_stall_cnt: got %0d expected 4", stall_cnt_o); end
`endif
        advance();
        n_tests++; if (ifid_pc4_o !== 32'h14 || ifid_instr_o !== 32'hC0DE_0010 || ifid_valid_o !== 1'b1) begin n_fail++; $display("FAIL delay_ifid: got %b/%h/%h expected 1/14/c0de0010", ifid_valid_o, ifid_pc4_o, ifid_instr_o); end
    endtask

    task automatic test_redirect();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        advance();
        drive(1'b0, 1'b0, 1'b1, 32'hD000_0000, 32'h0);
        advance();
        drive(1'b1, 1'b0, 1'b0, 32'hEEEE_EEEE, 32'h40);
        n_tests++; if (imem_addr_o !== 32'h4) begin n_fail++; $display("FAIL redir_pre_addr: got %h expected 4", imem_addr_o); end
        advance();
        drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0);
        n_tests++; if (ifid_valid_o !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b expected 0", ifid_valid_o); end
        n_tests++; if (imem_addr_o !== 32'h4 || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL redir_drop_addr: got %h/%b expected 4/1", imem_addr_o, imem_req_o); end
        advance();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_4040, 32'h0);
        n_tests++; if (imem_addr_o !== 32'h40 || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL redir_new_addr: got %h/%b expected 40/1", imem_addr_o, imem_req_o); end
        n_tests++; if (ifid_valid_o !== 1'b0) begin n_fail++; $display("FAIL redir_discard: got %b expected 0", ifid_valid_o); end
        advance();
        n_tests++; if (ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'h44 || ifid_instr_o !== 32'h0000_4040) begin n_fail++; $display("FAIL redir_target_ifid: got %b/%h/%h expected 1/44/4040", ifid_valid_o, ifid_pc4_o, ifid_instr_o); end
        drive(1'b1, 1'b0, 1'b1, 32'hEEEE_EEEE, 32'h80);
        advance();
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        n_tests++; if (ifid_valid_o !== 1'b0 || imem_addr_o !== 32'h80 || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL redir_ack_same: got %b/%h/%b expected 0/80/1", ifid_valid_o, imem_addr_o, imem_req_o); end
        advance();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        advance();
        drive(1'b0, 1'b0, 1'b1, 32'hF000_0000, 32'h0);
        advance();
        drive(1'b0, 1'b1, 1'b1, 32'hF000_0001, 32'h0);
        advance();
        drive(1'b0, 1'b1, 1'b1, 32'hEEEE_EEEE, 32'h0);
        n_tests++; if (imem_req_o !== 1'b0 || ifid_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_before_rst: got %b/%b expected 0/1", imem_req_o, ifid_valid_o); end
        rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++; if (pc_o !== 32'h0 || imem_req_o !== 1'b0) begin n_fail++; $display("FAIL hold_rst_pc: got %h/%b expected 0/0", pc_o, imem_req_o); end
        n_tests++; if (ifid_valid_o !== 1'b0 || ifid_pc4_o !== 32'h0 || ifid_instr_o !== 32'h0) begin n_fail++; $display("FAIL hold_rst_ifid: got %b/%h/%h expected 0/0/0", ifid_valid_o, ifid_pc4_o, ifid_instr_o); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 32'hEEEE_EEEE, 32'h0);
        n_tests++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL hold_rst_boot: got %b expected 0", imem_req_o); end
        advance();
        drive(1'b0, 1'b0, 1'b1, 32'h9999_0000, 32'h0);
        n_tests++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || ifid_valid_o !== 1'b0) begin n_fail++; $display("FAIL hold_rst_restart: got %b/%h/%b expected 1/0/0", imem_req_o, imem_addr_o, ifid_valid_o); end
        advance();
    endtask

    task automatic test_wrap();
        do_reset();
        w_next_pc = WRAP_PC + 32'd4;
        n_tests++; if (w_pc !== WRAP_PC || w_pc4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h/%h expected fffffffc/0", w_pc, w_pc4); end
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        advance();
        n_tests++; if (w_req !== 1'b1 || w_addr !== WRAP_PC) begin n_fail++; $display("FAIL wrap_first_addr: got %b/%h expected 1/fffffffc", w_req, w_addr); end
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        advance();
        n_tests++; if (w_addr !== 32'h0 || w_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr: got %h/%h expected 0/0", w_addr, w_pc); end
        n_tests++; if (w_ifid_valid !== 1'b1 || w_ifid_pc4 !== 32'h0 || w_ifid_instr !== 32'h1234_5678) begin n_fail++; $display("FAIL wrap_ifid: got %b/%h/%h expected 1/0/12345678", w_ifid_valid, w_ifid_pc4, w_ifid_instr); end
    endtask

    task automatic test_random();
        logic rd, st, ak;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rd = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 2) == 0);
            ak = ($urandom_range(0, 3) != 0);
            drive(rd, st, ak, $urandom, $urandom);
            n_tests++; if (imem_req_o !== (!m_boot && m_held.size() == 0)) begin n_fail++; $display("FAIL rnd_req@%0d: got %b expected %b", c, imem_req_o, !m_boot && m_held.size() == 0); end
            if (!m_boot && m_held.size() == 0) begin
                n_tests++; if (imem_addr_o !== (m_drop ? m_drop_addr : m_pc)) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h expected %h", c, imem_addr_o, m_drop ? m_drop_addr : m_pc); end
            end
            n_tests++; if (pc_o !== m_pc || pc4_o !== m_pc + 32'd4) begin n_fail++; $display("FAIL rnd_pc@%0d: got %h/%h expected %h/%h", c, pc_o, pc4_o, m_pc, m_pc + 32'd4); end
            n_tests++; if (ifid_valid_o !== m_v) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, ifid_valid_o, m_v); end
            n_tests++; if (ifid_pc4_o !== m_ipc4 || ifid_instr_o !== m_ins) begin n_fail++; $display("FAIL rnd_ifid@%0d: got %h/%h expected %h/%h", c, ifid_pc4_o, ifid_instr_o, m_ipc4, m_ins); end
`ifdef FETCH_STALL_CNT_EN
            n_tests++; if (stall_cnt_o !== m_cnt) begin n_fail++; $display("FAIL rnd_stall_cnt@%0d: got %0d expected %0d", c, stall_cnt_o, m_cnt); end
`endif
            advance();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall_hold();
        test_ack_delay();
        test_redirect();
        test_reset_mid_hold();
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
